// File: rtl/packed_lane_pkg.sv
// Shared types and sizing helpers for the packed lane packer.
// Build option: PACKED_LANE_SAT_EN selects saturating lane-0 combine.
package packed_lane_pkg;

  localparam int MAX_LANES = 16;
  localparam int DEFAULT_LANE_W = 8;

  // Packages cannot take parameters, so this is the default-width lane.
  // Modules with a different LANE_W declare their own lane_t of that width.
  typedef logic [DEFAULT_LANE_W-1:0] lane_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int count_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/lane_combine.sv
// Lane-0 combine: sum of two lane values, wrapping by default or saturating
// when PACKED_LANE_SAT_EN is defined.
module lane_combine #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);

`ifdef PACKED_LANE_SAT_EN
  logic [LANE_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign y   = sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
`else
  // The carry out of the LANE_W-bit add is simply dropped.
  assign y = a + b;
`endif

endmodule

// File: rtl/packed_lane_packer.sv
// Gathers LANE_W-bit elements into a LANES-wide packed word, lane 0 first,
// with an early close on in_last. Build option: PACKED_LANE_SAT_EN.
module packed_lane_packer
  import packed_lane_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int LANES  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANE_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*LANE_W-1:0]     out_data,
  output logic [LANE_W-1:0]           out_top,
  output logic [count_w(LANES)-1:0]   out_count
);

  localparam int IDX_W = count_w(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef logic [LANE_W-1:0] word_lane_t;

  if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
    $error("packed_lane_packer: LANES must be in 1..16");
  end

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  word_lane_t               lane_q [LANES];
  logic [LANES*LANE_W-1:0]  data_q;
  word_lane_t               top_q;
  logic [IDX_W-1:0]         count_q;

  logic                     accept;
  logic                     emit;
  logic                     closing;
  logic                     load_en;
  word_lane_t               comb_a;
  word_lane_t               comb_y;
  logic [LANES*LANE_W-1:0]  load_word;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign closing   = accept && (in_last || (idx_q == LAST_IDX));

  // The closing element never sits in the buffer first, so it is taken
  // straight from in_data both as the top lane and as the combine partner.
  assign comb_a = (idx_q == '0) ? in_data : lane_q[0];

  lane_combine #(
    .LANE_W (LANE_W)
  ) u_combine (
    .a (comb_a),
    .b (in_data),
    .y (comb_y)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_load
    localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
    if (gi == 0) begin : g_lane0
      assign load_word[0 +: LANE_W] = comb_y;
    end else begin : g_upper
      assign load_word[gi*LANE_W +: LANE_W] =
        (idx_q == GI_IDX) ? in_data :
        (GI_IDX < idx_q)  ? lane_q[gi] : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    idx_d   = idx_q;
    if (accept) begin
      idx_d = closing ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      FILL: begin
        if (closing) begin
          state_d = HOLD;
          load_en = 1'b1;
        end
      end
      HOLD: begin
        if (closing) begin
          load_en = 1'b1;
        end else if (emit) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      top_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_en) begin
        data_q  <= load_word;
        top_q   <= in_data;
        count_q <= idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (accept && (idx_q == IDX_W'(i))) begin
          lane_q[i] <= in_data;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_top   = top_q;
  assign out_count = count_q;

endmodule
